// File: rtl/pic_nested.sv
// Nested-priority interrupt controller: latches device requests, arbitrates by
// line index against the in-service set, and exposes a small register window.
module pic_nested #(
  parameter int                NUM_IRQ  = 8,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] VEC_BASE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               INT,
  input  logic               intack,
  output logic [DATA_W-1:0]  vector,
  input  logic               sel,
  input  logic [1:0]         a,
  input  logic               wr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  localparam int IW = $clog2(NUM_IRQ + 1);

  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;

  logic [NUM_IRQ-1:0] req, win_oh, cur_oh, set_v, wdata_n;
  logic [IW-1:0]      win, cur;
  logic               int_req, ack, wr_en;
  logic [DATA_W-1:0]  unused_wdata;

  assign unused_wdata = wdata;
  assign wdata_n      = wdata[NUM_IRQ-1:0];

  // Lowest set bit of a vector isolates the highest-priority line as a one-hot mask.
  always_comb begin
    req     = pending_q & ~mask_q;
    win_oh  = req & (~req + NUM_IRQ'(1));
    cur_oh  = isr_q & (~isr_q + NUM_IRQ'(1));
    win     = IW'(NUM_IRQ);
    cur     = IW'(NUM_IRQ);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i])   win = IW'(i);
      if (isr_q[i]) cur = IW'(i);
    end
    int_req = (req != '0) && (win < cur);
  end

  assign INT    = int_req;
  assign vector = VEC_BASE + DATA_W'(int_req ? win : IW'(NUM_IRQ));

  // Clears are applied first so a same-cycle set always survives.
  always_comb begin
    wr_en      = sel & wr;
    ack        = intack & int_req;
    set_v      = irq_in & ~(mode_q & irq_prev_q);
    irq_prev_d = irq_in;

    mask_d = (wr_en && a == 2'd0) ? wdata_n : mask_q;
    mode_d = (wr_en && a == 2'd2) ? wdata_n : mode_q;

    pending_d = pending_q;
    if (ack)                  pending_d = pending_d & ~win_oh;
    if (wr_en && a == 2'd1)   pending_d = pending_d & ~wdata_n;
    pending_d = pending_d | set_v;

    isr_d = isr_q;
    if (wr_en && a == 2'd3)   isr_d = isr_d & ~cur_oh;
    if (ack)                  isr_d = isr_d | win_oh;
  end

  always_comb begin
    rdata = '0;
    case (a)
      2'd0:    rdata[NUM_IRQ-1:0] = mask_q;
      2'd1:    rdata[NUM_IRQ-1:0] = pending_q;
      2'd2:    rdata[NUM_IRQ-1:0] = mode_q;
      default: rdata[NUM_IRQ-1:0] = isr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '1;
      mode_q     <= '0;
      pending_q  <= '0;
      isr_q      <= '0;
      irq_prev_q <= '0;
    end else begin
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      pending_q  <= pending_d;
      isr_q      <= isr_d;
      irq_prev_q <= irq_prev_d;
    end
  end

endmodule

// File: tb/tb_pic_nested.sv
// Scoreboard bench for pic_nested: stimulus queues expected outputs, a negedge
// monitor pops them whenever the DUT presents a vector, read data or INT probe.
module tb_pic_nested;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_in;
  logic        INT;
  logic        intack;
  logic [15:0] vector;
  logic        sel;
  logic [1:0]  a;
  logic        wr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        int_chk;

  typedef enum {K_VEC, K_RD, K_INT} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pic_nested #(.NUM_IRQ(8), .DATA_W(16), .VEC_BASE(16'h0000)) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .INT    (INT),
    .intack (intack),
    .vector (vector),
    .sel    (sel),
    .a      (a),
    .wr     (wr),
    .wdata  (wdata),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: any cycle with an observable output consumes one scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [15:0] act;
    if (!rst && (intack || (sel && !wr) || int_chk)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL scoreboard_empty: got an output, expected no output");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          K_VEC:   act = intack ? vector : 16'hxxxx;
          K_RD:    act = (sel && !wr) ? rdata : 16'hxxxx;
          default: act = int_chk ? {15'd0, INT} : 16'hxxxx;
        endcase
        checkOutput(e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack_v, input logic sel_v, input logic wr_v,
                               input logic [1:0] a_v, input logic [15:0] d_v, input logic chk_v);
    intack  = ack_v;
    sel     = sel_v;
    wr      = wr_v;
    a       = a_v;
    wdata   = d_v;
    int_chk = chk_v;
    tick();
    intack  = 1'b0;
    sel     = 1'b0;
    wr      = 1'b0;
    int_chk = 1'b0;
  endtask

  task automatic push_exp(input kind_e k, input logic [15:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic write_reg(input logic [1:0] ra, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, 1'b1, ra, d, 1'b0);
  endtask

  task automatic read_reg(input logic [1:0] ra, input logic [15:0] exp, input string n);
    push_exp(K_RD, exp, n);
    applyStimulus(1'b0, 1'b1, 1'b0, ra, 16'h0000, 1'b0);
  endtask

  task automatic do_ack(input logic [15:0] exp, input string n);
    push_exp(K_VEC, exp, n);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
  endtask

  task automatic ack_write(input logic [1:0] ra, input logic [15:0] d, input logic [15:0] exp, input string n);
    push_exp(K_VEC, exp, n);
    applyStimulus(1'b1, 1'b1, 1'b1, ra, d, 1'b0);
  endtask

  task automatic probe_int(input logic exp, input string n);
    push_exp(K_INT, {15'd0, exp}, n);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq_in = m;
    tick();
    irq_in = 8'h00;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; irq_in = 8'h00; intack = 1'b0; sel = 1'b0; wr = 1'b0;
    a = 2'd0; wdata = 16'h0000; int_chk = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    read_reg(2'd0, 16'h00FF, "rst_mask");
    read_reg(2'd1, 16'h0000, "rst_pending");
    read_reg(2'd2, 16'h0000, "rst_mode");
    read_reg(2'd3, 16'h0000, "rst_isr");
    probe_int(1'b0, "rst_int");
    do_ack(16'h0008, "rst_spurious_vec");

    $display("[TB] single level line 2");
    write_reg(2'd0, 16'h0000);
    irq_in = 8'h04;
    probe_int(1'b0, "t1_int_before_edge");
    probe_int(1'b1, "t1_int_latency");
    do_ack(16'h0002, "t1_vec");
    read_reg(2'd3, 16'h0004, "t1_isr");
    read_reg(2'd1, 16'h0004, "t1_level_repend");
    probe_int(1'b0, "t1_isr_blocks_reentry");
    irq_in = 8'h00;
    write_reg(2'd1, 16'h0004);
    write_reg(2'd3, 16'h0000);
    read_reg(2'd3, 16'h0000, "t1_isr_after_eoi");
    read_reg(2'd1, 16'h0000, "t1_pending_w1c");

    $display("[TB] simultaneous lines 1 and 5");
    pulse_irq(8'h22);
    probe_int(1'b1, "t2_int");
    do_ack(16'h0001, "t2_vec_first");
    probe_int(1'b0, "t2_no_nest_lower");
    read_reg(2'd1, 16'h0020, "t2_pending");
    write_reg(2'd3, 16'h0000);
    probe_int(1'b1, "t2_int_after_eoi");
    do_ack(16'h0005, "t2_vec_second");
    read_reg(2'd3, 16'h0020, "t2_isr");
    write_reg(2'd3, 16'h0000);

    $display("[TB] nesting");
    pulse_irq(8'h10);
    do_ack(16'h0004, "t3_vec4");
    read_reg(2'd3, 16'h0010, "t3_isr4");
    pulse_irq(8'h01);
    probe_int(1'b1, "t3_nest_int");
    do_ack(16'h0000, "t3_vec0");
    read_reg(2'd3, 16'h0011, "t3_isr_nested");
    write_reg(2'd3, 16'h0000);
    read_reg(2'd3, 16'h0010, "t3_isr_first_eoi");
    write_reg(2'd3, 16'h0000);
    read_reg(2'd3, 16'h0000, "t3_isr_second_eoi");

    $display("[TB] EOI together with intack");
    pulse_irq(8'h10);
    do_ack(16'h0004, "t3b_vec4");
    pulse_irq(8'h01);
    ack_write(2'd3, 16'hFFFF, 16'h0000, "t3b_vec0");
    read_reg(2'd3, 16'h0001, "t3b_isr");
    write_reg(2'd3, 16'h0000);
    read_reg(2'd3, 16'h0000, "t3b_isr_clear");

    $display("[TB] MASK write together with intack");
    pulse_irq(8'h40);
    ack_write(2'd0, 16'h00FF, 16'h0006, "tm_vec_old_mask");
    read_reg(2'd0, 16'h00FF, "tm_mask");
    read_reg(2'd3, 16'h0040, "tm_isr");
    read_reg(2'd1, 16'h0000, "tm_pending");
    write_reg(2'd3, 16'h0000);
    write_reg(2'd0, 16'h0000);

    $display("[TB] edge mode line 3");
    write_reg(2'd2, 16'h0008);
    irq_in = 8'h08;
    tick();
    probe_int(1'b1, "t4_int");
    do_ack(16'h0003, "t4_vec");
    repeat (6) tick();
    read_reg(2'd1, 16'h0000, "t4_no_repend");
    read_reg(2'd3, 16'h0008, "t4_isr");
    irq_in = 8'h00;
    read_reg(2'd2, 16'h0008, "t4_mode");
    write_reg(2'd3, 16'h0000);
    write_reg(2'd2, 16'h0000);

    $display("[TB] masking");
    write_reg(2'd0, 16'h0004);
    pulse_irq(8'h04);
    probe_int(1'b0, "t5_masked_int");
    read_reg(2'd1, 16'h0004, "t5_masked_pending");
    do_ack(16'h0008, "t5_spurious_vec");
    read_reg(2'd1, 16'h0004, "t5_pending_kept");
    read_reg(2'd3, 16'h0000, "t5_isr_kept");
    write_reg(2'd0, 16'h0000);
    probe_int(1'b1, "t5_unmask_int");
    write_reg(2'd0, 16'h0004);
    write_reg(2'd1, 16'h0004);
    read_reg(2'd1, 16'h0000, "t5_w1c");

    $display("[TB] reset mid-service");
    write_reg(2'd0, 16'h0000);
    pulse_irq(8'h02);
    do_ack(16'h0001, "t6_vec1");
    pulse_irq(8'h08);
    probe_int(1'b0, "t6_int_blocked");
    read_reg(2'd1, 16'h0008, "t6_pending");
    read_reg(2'd3, 16'h0002, "t6_isr");
    write_reg(2'd2, 16'h0080);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read_reg(2'd0, 16'h00FF, "t6_mask");
    read_reg(2'd1, 16'h0000, "t6_pending_rst");
    read_reg(2'd2, 16'h0000, "t6_mode");
    read_reg(2'd3, 16'h0000, "t6_isr_rst");
    probe_int(1'b0, "t6_int_rst");
    do_ack(16'h0008, "t6_spurious_vec");

    tick();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_leftover: got %0d unconsumed entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
